// File: rtl/cart_pkg.sv
// Shared types and constants for the CoCo2 cartridge loader.
package cart_pkg;

  localparam int unsigned CART_SIZE  = 16384;
  localparam int unsigned HALF_SIZE  = 8192;
  localparam logic [7:0]  CART_INDEX = 8'h01;
  localparam logic [7:0]  FILL_BYTE  = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StMirror,
    StDone
  } cart_state_e;

endpackage

// File: rtl/cart_ram.sv
// Simple dual-port block RAM: one write port, one registered read port.
module cart_ram #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/cart_loader.sv
// Captures an ioctl cartridge download into RAM, mirrors small images into the
// upper half, and serves CPU reads with one cycle of latency.
module cart_loader #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned HALF_SIZE  = 8192,
  parameter logic [7:0]  CART_INDEX = 8'h01
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [15:0]       ioctl_addr,
  input  logic [7:0]        ioctl_data,
  input  logic [7:0]        ioctl_index,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rd,
  output logic [7:0]        cpu_dout,
  output logic              cart_present,
  output logic [ADDR_W:0]   cart_len,
  output logic              busy,
  output logic              overflow
);

  import cart_pkg::*;

  localparam int unsigned LenW = ADDR_W + 1;
  localparam int unsigned MirW = ADDR_W - 1;
  localparam logic [ADDR_W:0] HalfLen = LenW'(HALF_SIZE);

  cart_state_e state_q, state_d;

  logic              dl_q;
  logic [ADDR_W:0]   len_q, len_d;
  logic              ovf_q, ovf_d;
  logic [MirW-1:0]   m_q, m_d, mw_q;
  logic              rd_done_q, rd_done_d;
  logic              wr_pend_q;
  logic              rd_pend_q, fill_q;
  logic [7:0]        hold_q;

  logic              start;
  logic              in_range;
  logic [ADDR_W:0]   wr_len;
  logic [ADDR_W:0]   eff;
  logic              fill_req;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [7:0]        ram_wdata, ram_rdata;

  assign start    = ioctl_download && !dl_q && (ioctl_index == CART_INDEX);
  assign in_range = (ioctl_addr >> ADDR_W) == '0;
  assign wr_len   = {1'b0, ioctl_addr[ADDR_W-1:0]} + LenW'(1);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    m_d       = m_q;
    rd_done_d = rd_done_q;
    ram_we    = 1'b0;
    ram_waddr = ioctl_addr[ADDR_W-1:0];
    ram_wdata = ioctl_data;
    ram_raddr = cpu_addr;

    unique case (state_q)
      StLoad: begin
        m_d       = '0;
        rd_done_d = 1'b0;
        if (ioctl_wr) begin
          if (in_range) begin
            ram_we = 1'b1;
            if (wr_len > len_q) len_d = wr_len;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (!ioctl_download) begin
          if (len_d == '0)          state_d = StIdle;
          else if (len_d <= HalfLen) state_d = StMirror;
          else                       state_d = StDone;
        end
      end
      StMirror: begin
        // Read low half at m, write the byte one cycle later into the high half.
        ram_raddr = {1'b0, m_q};
        ram_we    = wr_pend_q;
        ram_waddr = {1'b1, mw_q};
        ram_wdata = ram_rdata;
        if (!rd_done_q) begin
          m_d = m_q + 1'b1;
          if (&m_q) rd_done_d = 1'b1;
        end else begin
          state_d = StDone;
        end
      end
      default: ;
    endcase

    if (start) begin
      state_d = StLoad;
      len_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  assign busy         = (state_q == StLoad) || (state_q == StMirror);
  assign cart_present = (state_q == StDone);
  assign cart_len     = len_q;
  assign overflow     = ovf_q;

  // Images of half size or less alias the upper half onto the lower one.
  assign eff      = (len_q <= HalfLen) ? {2'b00, cpu_addr[ADDR_W-2:0]} : {1'b0, cpu_addr};
  assign fill_req = busy || !cart_present || (eff >= len_q);
  assign cpu_dout = rd_pend_q ? (fill_q ? FILL_BYTE : ram_rdata) : hold_q;

  always_ff @(posedge clk) begin
    // Tracks the input even in reset so a held download does not retrigger.
    dl_q <= ioctl_download;
    mw_q <= m_q;
    if (!reset) begin
      state_q   <= StIdle;
      len_q     <= '0;
      ovf_q     <= 1'b0;
      m_q       <= '0;
      rd_done_q <= 1'b0;
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
      fill_q    <= 1'b1;
      hold_q    <= FILL_BYTE;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
      m_q       <= m_d;
      rd_done_q <= rd_done_d;
      wr_pend_q <= (state_q == StMirror) && !rd_done_q;
      rd_pend_q <= cpu_rd;
      if (cpu_rd) fill_q <= fill_req;
      hold_q    <= cpu_dout;
    end
  end

  cart_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(8)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_cart_loader.sv
// Self-checking bench for cart_loader: read tables plus multi-cycle sequences.
module tb_cart_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [15:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic [7:0]  ioctl_index;
  logic [13:0] cpu_addr;
  logic        cpu_rd;
  logic [7:0]  cpu_dout;
  logic        cart_present;
  logic [14:0] cart_len;
  logic        busy;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [13:0] addr;
    logic [7:0]  exp;
  } rd_vec_t;

  rd_vec_t t1[6];
  rd_vec_t t2[4];
  rd_vec_t t3[4];
  logic [7:0] exp_q[$];

  cart_loader dut (
    .clk           (clk),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_data    (ioctl_data),
    .ioctl_index   (ioctl_index),
    .cpu_addr      (cpu_addr),
    .cpu_rd        (cpu_rd),
    .cpu_dout      (cpu_dout),
    .cart_present  (cart_present),
    .cart_len      (cart_len),
    .busy          (busy),
    .overflow      (overflow)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic wr_byte(input logic [15:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  // Drops the download and counts cycles busy stays high after the falling edge.
  task automatic end_dl(output int n);
    ioctl_download = 1'b0;
    tick();
    n = 0;
    while (busy === 1'b1 && n < 20000) begin
      n++;
      tick();
    end
  endtask

  task automatic rd(input logic [13:0] a, input logic [7:0] e, input string nm);
    logic [7:0] got;
    cpu_addr = a;
    cpu_rd   = 1'b1;
    exp_q.push_back(e);
    tick();
    cpu_rd = 1'b0;
    got    = cpu_dout;
    chk(nm, {24'h0, got}, {24'h0, exp_q.pop_front()});
  endtask

  initial begin
    int n;
    logic [13:0] a14;

    t1[0] = '{14'h0002, 8'h00};
    t1[1] = '{14'h2001, 8'h5A};
    t1[2] = '{14'h0004, 8'hFF};
    t1[3] = '{14'h2004, 8'hFF};
    t1[4] = '{14'h0000, 8'hA5};
    t1[5] = '{14'h2003, 8'h37};
    t2[0] = '{14'h3FFF, 8'hC0};
    t2[1] = '{14'h1234, 8'h26};
    t2[2] = '{14'h0000, 8'h00};
    t2[3] = '{14'h2001, 8'h21};
    t3[0] = '{14'h0000, 8'h11};
    t3[1] = '{14'h0003, 8'hFF};
    t3[2] = '{14'h2002, 8'h33};
    t3[3] = '{14'h3FFF, 8'hFF};

    reset = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
    ioctl_data = '0; ioctl_index = 8'h01; cpu_addr = '0; cpu_rd = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_present", cart_present, 0);
    chk("rst_len", cart_len, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_dout", cpu_dout, 8'hFF);
    rd(14'h0000, 8'hFF, "rst_rd_empty");

    // Small image: mirrored.
    start_dl(8'h01);
    chk("s1_busy_load", busy, 1);
    wr_byte(16'h0000, 8'hA5);
    wr_byte(16'h0001, 8'h5A);
    wr_byte(16'h0002, 8'h00);
    wr_byte(16'h0003, 8'h37);
    end_dl(n);
    chk("s1_mirror_cycles", n, 8193);
    chk("s1_present", cart_present, 1);
    chk("s1_len", cart_len, 4);
    chk("s1_ovf", overflow, 0);
    foreach (t1[i]) rd(t1[i].addr, t1[i].exp, $sformatf("s1_rd_%h", t1[i].addr));
    cpu_addr = 14'h0001;
    tick();
    chk("s1_dout_hold", cpu_dout, 8'h37);

    // Non-cartridge index is ignored.
    start_dl(8'h00);
    chk("s4_busy", busy, 0);
    wr_byte(16'h0000, 8'h11);
    end_dl(n);
    chk("s4_present", cart_present, 1);
    rd(14'h0000, 8'hA5, "s4_rd_0000");

    // Full 16 KiB image: no mirror.
    start_dl(8'h01);
    for (int i = 0; i < 16384; i++) begin
      a14 = 14'(i);
      wr_byte(16'(i), a14[7:0] ^ {2'b00, a14[13:8]});
    end
    end_dl(n);
    chk("s2_busy_cycles", n, 0);
    chk("s2_present", cart_present, 1);
    chk("s2_len", cart_len, 16384);
    chk("s2_ovf", overflow, 0);
    foreach (t2[i]) rd(t2[i].addr, t2[i].exp, $sformatf("s2_rd_%h", t2[i].addr));

    // Out-of-range byte is dropped and flagged.
    start_dl(8'h01);
    wr_byte(16'h0000, 8'h11);
    wr_byte(16'h0001, 8'h22);
    wr_byte(16'h0002, 8'h33);
    wr_byte(16'h4000, 8'hEE);
    end_dl(n);
    chk("s3_mirror_cycles", n, 8193);
    chk("s3_ovf", overflow, 1);
    chk("s3_len", cart_len, 3);
    foreach (t3[i]) rd(t3[i].addr, t3[i].exp, $sformatf("s3_rd_%h", t3[i].addr));

    // New download aborts a mirror in progress.
    start_dl(8'h01);
    chk("s5_ovf_cleared", overflow, 0);
    wr_byte(16'h0000, 8'hA5);
    ioctl_download = 1'b0;
    repeat (100) tick();
    chk("s5_busy_mirror", busy, 1);
    rd(14'h0000, 8'hFF, "s5_rd_mirror");
    start_dl(8'h01);
    chk("s5_abort_present", cart_present, 0);
    chk("s5_abort_busy", busy, 1);
    chk("s5_abort_len", cart_len, 0);
    rd(14'h0000, 8'hFF, "s5_rd_load");
    for (int i = 0; i < 5; i++) wr_byte(16'(i), 8'(i + 1));
    end_dl(n);
    chk("s5_mirror_cycles", n, 8193);
    chk("s5_len", cart_len, 5);
    rd(14'h2004, 8'h05, "s5_rd_2004");
    rd(14'h2005, 8'hFF, "s5_rd_2005");
    rd(14'h0000, 8'h01, "s5_rd_0000");

    // Reset mid-load, then stray strobes with download still high.
    start_dl(8'h01);
    wr_byte(16'h0000, 8'h55);
    wr_byte(16'h0001, 8'h66);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("s6_busy", busy, 0);
    chk("s6_present", cart_present, 0);
    chk("s6_len", cart_len, 0);
    chk("s6_dout", cpu_dout, 8'hFF);
    wr_byte(16'h0002, 8'h77);
    tick();
    chk("s6_ignored_busy", busy, 0);
    chk("s6_ignored_len", cart_len, 0);
    end_dl(n);
    chk("s6_no_mirror", n, 0);
    start_dl(8'h01);
    wr_byte(16'h0000, 8'h99);
    end_dl(n);
    chk("s6_mirror_cycles", n, 8193);
    chk("s6_len_after", cart_len, 1);
    rd(14'h0000, 8'h99, "s6_rd_0000");
    rd(14'h2000, 8'h99, "s6_rd_2000");
    rd(14'h0001, 8'hFF, "s6_rd_0001");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
